alu_arbiter_seq: RTL
====================

Name: alu_arbiter_seq

Overview:
- Two-requester front end for one shared combinational N-bit ALU (5-bit opcode, W-bit A/B, W-bit result plus carry).
- Accepts one operation at a time from either requester using round-robin arbitration.
- Registers the operands onto the ALU inputs, captures the ALU result one cycle later, and returns it to the winning requester over a valid/ready response channel.
- Sits between the core's issue ports and the ALU instance. The ALU itself stays outside this block.

Parameters:
- W, 17: datapath width, matching an ALU instance with n=16 (bits [n:0]).
- CW, 16: width of the completed-operation counter.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- req_valid, in, 2: per-port request valid; bit i belongs to port i.
- req_ready, out, 2: per-port request accept.
- req_sel, in, 10: opcodes; port0 is [4:0], port1 is [9:5].
- req_a, in, 2*W: A operands; port0 is [W-1:0], port1 is [2W-1:W].
- req_b, in, 2*W: B operands; same packing as req_a.
- rsp_valid, out, 2: per-port response valid.
- rsp_ready, in, 2: per-port response accept.
- rsp_data, out, W: result, shared by both ports and qualified by rsp_valid.
- rsp_cout, out, 1: carry result, shared by both ports.
- alu_a, out, W: registered A operand driven to the ALU.
- alu_b, out, W: registered B operand driven to the ALU.
- alu_sel, out, 5: registered opcode driven to the ALU.
- alu_out, in, W: ALU result (combinational from alu_a/alu_b/alu_sel).
- alu_cout, in, 1: ALU carry.
- busy, out, 1: high whenever state is not IDLE.
- op_count, out, CW: count of completed responses.

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=1 (so port0 wins the first contention), gnt=0.
  - alu_a=0, alu_b=0, alu_sel=0.
  - rsp_valid=00, rsp_data=0, rsp_cout=0, op_count=0.
  - busy=0 and req_ready=00 follow from state.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. At most one bit is set, and only for the arbitration winner.
  - Only one req_valid bit high: that port wins.
  - Both high: the port != last_grant wins.
  - Neither high: req_ready=00 and the FSM stays in IDLE.
  - Transfer occurs when req_valid[i] & req_ready[i]. On that edge:
    - alu_a/alu_b/alu_sel load port i's operands.
    - gnt=i and last_grant=i.
    - state goes to EXEC.
- EXEC:
  - Exactly one cycle, with req_ready=00.
  - On the edge: rsp_data<=alu_out, rsp_cout<=alu_cout, rsp_valid[gnt]<=1, state goes to RESP.
- RESP:
  - rsp_valid[gnt] is held high; rsp_data and rsp_cout are held stable; req_ready=00.
  - When rsp_ready[gnt]=1, on that edge: rsp_valid<=00, op_count<=op_count+1 (wraps mod 2^CW), state goes to IDLE.
- Latency and throughput:
  - Request accepted in cycle T gives rsp_valid high in cycle T+2.
  - Minimum issue interval is 3 cycles (a new accept is possible in the first IDLE cycle).
- alu_a, alu_b and alu_sel hold their last values after completion. They are not cleared.
- rsp_data and rsp_cout also hold after completion, qualified only by rsp_valid.
- rsp_ready on the non-granted port is ignored in every state. rsp_ready in IDLE or EXEC has no effect.
- Requesters may drop req_valid before acceptance with no effect on the block. Requesters must not make req_valid depend on req_ready.
- req_valid asserted during EXEC or RESP waits; no request is ever lost or reordered within a port.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1,...
- Reset mid-operation: everything returns to reset values immediately (asynchronously). Any pending result is discarded without a response, and last_grant returns to 1.
- Only one operation is in flight, so rsp_valid is never 11.

Test Plan:
1. After reset, port0 only: sel=00000, A=5, B=3 -> req_ready=01 in the same cycle; rsp_valid=01 two cycles later with rsp_data=8, rsp_cout=0; rsp_ready[0]=1 -> op_count=1, busy=0.
2. Both ports valid continuously (port0 sel=00000 A=10 B=4; port1 sel=00001 A=10 B=4), rsp_ready=11 -> grant order 0,1,0,1; responses 14 on port0 and 6 on port1; an op completes every 3 cycles.
3. Backpressure: single op, then hold rsp_ready=00 for 5 cycles while both req_valid are high -> rsp_valid and rsp_data stable, req_ready=00, busy=1; release -> the next grant goes to the port opposite the last winner.
4. Carry: port1 add with A=17'h1FFFF, B=1 -> rsp_data=0, rsp_cout=1, rsp_valid=10.
5. Assert reset during EXEC -> all outputs zero immediately, no rsp_valid, op_count=0; after release with both ports requesting -> port0 wins first.
6. With CW=4, complete 16 ops -> op_count returns to 0; the 17th completion gives op_count=1.

Source files
------------

// File: rtl/alu_arbiter_seq_if.sv
// Request/response bundle between two issue ports and the shared-ALU front end.
// Port i owns bit i of each valid/ready pair and slice i of each packed operand bus.
interface alu_arbiter_seq_if #(
   parameter int unsigned W = 17
) ();
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [9:0]     req_sel;
   logic [2*W-1:0] req_a;
   logic [2*W-1:0] req_b;
   logic [1:0]     rsp_valid;
   logic [1:0]     rsp_ready;
   logic [W-1:0]   rsp_data;
   logic           rsp_cout;

   modport master (
      output req_valid, req_sel, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_cout
   );

   modport slave (
      input  req_valid, req_sel, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_cout
   );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Round-robin two-port front end for one shared combinational ALU.
// One operation in flight: accept -> register operands -> capture result -> hold response.
module alu_arbiter_seq #(
   parameter int unsigned W  = 17,
   parameter int unsigned CW = 16
) (
   input  logic                clock,
   input  logic                reset,
   alu_arbiter_seq_if.slave    bus,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   output logic [4:0]          alu_sel,
   input  logic [W-1:0]        alu_out,
   input  logic                alu_cout,
   output logic                busy,
   output logic [CW-1:0]       op_count
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e       state_q, state_d;
   logic         gnt_q;
   logic         last_grant_q;
   logic [1:0]   rsp_valid_q;
   logic [W-1:0] rsp_data_q;
   logic         rsp_cout_q;
   logic [1:0]   req_ready;
   logic         win;
   logic         accept;
   logic         complete;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 2'b00;
      accept    = 1'b0;
      complete  = 1'b0;
      // Lone requester wins; on contention the port that did not win last time wins.
      win       = (bus.req_valid == 2'b10) || ((bus.req_valid == 2'b11) && !last_grant_q);
      unique case (state_q)
         StIdle: begin
            if (|bus.req_valid) begin
               req_ready = win ? 2'b10 : 2'b01;
               accept    = 1'b1;
               state_d   = StExec;
            end
         end
         StExec: state_d = StResp;
         StResp: begin
            if (bus.rsp_ready[gnt_q]) begin
               complete = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= '0;
         rsp_valid_q  <= 2'b00;
         rsp_data_q   <= '0;
         rsp_cout_q   <= 1'b0;
         op_count     <= '0;
      end else begin
         if (accept) begin
            alu_a        <= win ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
            alu_b        <= win ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
            alu_sel      <= win ? bus.req_sel[9:5]   : bus.req_sel[4:0];
            gnt_q        <= win;
            last_grant_q <= win;
         end
         if (state_q == StExec) begin
            rsp_data_q  <= alu_out;
            rsp_cout_q  <= alu_cout;
            rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
         end
         if (complete) begin
            rsp_valid_q <= 2'b00;
            op_count    <= op_count + CW'(1);
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign busy          = (state_q != StIdle);

endmodule
